// File: rtl/line_mem_ctrl_if.sv
// Bundle between the line memory controller and its ADDR/WDATA FIFOs, RAM and ring read bus.
// The master side is the controller; the slave side is the surrounding FIFOs and RAM.
interface line_mem_ctrl_if #(
  parameter int unsigned SSIZE       = 4,
  parameter int unsigned NBWORDS     = 3,
  parameter int unsigned NBCACHELINE = 27,
  parameter int unsigned MBITS       = 14
);
  logic                         addr_empty;
  logic [SSIZE+NBCACHELINE:0]   addr_out;
  logic                         addr_rd;
  logic                         wdata_empty;
  logic [31:0]                  wdata_data;
  logic                         wdata_rd;
  logic [MBITS-1:0]             ram_addr;
  logic                         ram_we;
  logic [31:0]                  ram_wdata;
  logic                         ram_re;
  logic [31:0]                  ram_rdata;
  logic [SSIZE-1:0]             mc_dest;
  logic [NBWORDS-1:0]           mc_count;
  logic [31:0]                  mc_data;
  logic                         err_valid;
  logic [SSIZE-1:0]             err_src;
  logic [NBCACHELINE-1:0]       err_line;
  logic                         busy;

  modport master (
    input  addr_empty, addr_out, wdata_empty, wdata_data, ram_rdata,
    output addr_rd, wdata_rd, ram_addr, ram_we, ram_wdata, ram_re,
           mc_dest, mc_count, mc_data, err_valid, err_src, err_line, busy
  );

  modport slave (
    output addr_empty, addr_out, wdata_empty, wdata_data, ram_rdata,
    input  addr_rd, wdata_rd, ram_addr, ram_we, ram_wdata, ram_re,
           mc_dest, mc_count, mc_data, err_valid, err_src, err_line, busy
  );
endinterface

// File: rtl/line_mem_ctrl.sv
// Line memory controller: pops cache-line requests and moves NWORDS words between the
// WDATA FIFO, a synchronous RAM and the two-stage ring read bus; out-of-range lines are dropped.
module line_mem_ctrl #(
  parameter int unsigned SSIZE       = 4,
  parameter int unsigned NBWORDS     = 3,
  parameter int unsigned NBCACHELINE = 27,
  parameter int unsigned MBITS       = 14
) (
  input logic             clk,
  input logic             reset,
  line_mem_ctrl_if.master bus
);
  localparam int unsigned LBITS = MBITS - NBWORDS;

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StErr, StDiscard} state_e;

  state_e                 state_q;
  logic [SSIZE-1:0]       dest_q;
  logic [NBCACHELINE-1:0] line_q;
  logic [NBWORDS-1:0]     word_q;

  logic                   s1_valid_q;
  logic [SSIZE-1:0]       s1_dest_q;
  logic [NBWORDS-1:0]     s1_word_q;

  logic [SSIZE-1:0]       mc_dest_q;
  logic [NBWORDS-1:0]     mc_count_q;
  logic [31:0]            mc_data_q;
  logic                   err_valid_q;
  logic [SSIZE-1:0]       err_src_q;
  logic [NBCACHELINE-1:0] err_line_q;

  logic [SSIZE-1:0]       head_dest;
  logic                   head_rw;
  logic [NBCACHELINE-1:0] head_line;
  logic                   head_oor;
  logic                   last_word;
  logic                   ram_re, ram_we, wdata_rd, addr_rd;

  assign head_dest = bus.addr_out[SSIZE+NBCACHELINE:NBCACHELINE+1];
  assign head_rw   = bus.addr_out[NBCACHELINE];
  assign head_line = bus.addr_out[NBCACHELINE-1:0];
  assign head_oor  = |head_line[NBCACHELINE-1:LBITS];
  assign last_word = &word_q;

  always_comb begin
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    wdata_rd = 1'b0;
    addr_rd  = 1'b0;
    case (state_q)
      StRead: begin
        ram_re  = 1'b1;
        addr_rd = last_word;
      end
      StWrite: begin
        ram_we   = !bus.wdata_empty;
        wdata_rd = !bus.wdata_empty;
        addr_rd  = !bus.wdata_empty && last_word;
      end
      StDiscard: begin
        wdata_rd = !bus.wdata_empty;
        addr_rd  = !bus.wdata_empty && last_word;
      end
      StErr:   addr_rd = 1'b1;
      default: ;
    endcase
  end

  assign bus.ram_re    = ram_re;
  assign bus.ram_we    = ram_we;
  assign bus.wdata_rd  = wdata_rd;
  assign bus.addr_rd   = addr_rd;
  // Address and data are zeroed outside strobe cycles so an idle controller drives all zeros.
  assign bus.ram_addr  = (ram_re || ram_we) ? {line_q[LBITS-1:0], word_q} : '0;
  assign bus.ram_wdata = ram_we ? bus.wdata_data : '0;
  assign bus.mc_dest   = mc_dest_q;
  assign bus.mc_count  = mc_count_q;
  assign bus.mc_data   = mc_data_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_src   = err_src_q;
  assign bus.err_line  = err_line_q;
  assign bus.busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dest_q      <= '0;
      line_q      <= '0;
      word_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_dest_q   <= '0;
      s1_word_q   <= '0;
      mc_dest_q   <= '0;
      mc_count_q  <= '0;
      mc_data_q   <= '0;
      err_valid_q <= 1'b0;
      err_src_q   <= '0;
      err_line_q  <= '0;
    end else begin
      // Read pipeline runs independently of the FSM so bursts drain after the line ends.
      s1_valid_q  <= ram_re;
      s1_dest_q   <= ram_re ? dest_q : '0;
      s1_word_q   <= ram_re ? word_q : '0;
      mc_dest_q   <= s1_valid_q ? s1_dest_q : '0;
      mc_count_q  <= s1_valid_q ? s1_word_q : '0;
      mc_data_q   <= s1_valid_q ? bus.ram_rdata : '0;
      err_valid_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (!bus.addr_empty) begin
            dest_q <= head_dest;
            line_q <= head_line;
            word_q <= '0;
            if (head_oor) begin
              err_valid_q <= 1'b1;
              err_src_q   <= head_dest;
              err_line_q  <= head_line;
              state_q     <= head_rw ? StDiscard : StErr;
            end else begin
              state_q <= head_rw ? StWrite : StRead;
            end
          end
        end
        StRead: begin
          word_q <= word_q + 1'b1;
          if (last_word) state_q <= StIdle;
        end
        StWrite, StDiscard: begin
          if (wdata_rd) begin
            word_q <= word_q + 1'b1;
            if (last_word) state_q <= StIdle;
          end
        end
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
